gng_burst_ctrl: RTL and testbench

//  Sequences a complex Gaussian noise generator (16-bit real/imag, s<16,11>) into bursts of

---
 rtl/gng_burst_ctrl.sv | 169 ++++++++++++++++
 tb/tb_gng_burst_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gng_burst_ctrl.sv
// gng_burst_ctrl
//   Sequences a complex Gaussian noise generator into bursts of programmable
//   length and gap, and delivers the samples on an AXI-Stream master through
//   a first-word-fall-through FIFO. The generator is only enabled while the
//   FIFO has room for every sample already requested, so backpressure never
//   loses samples produced under gen_ce.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   start, stop               control pulses (start latches the config)
//   burst_len/gap_len         samples per burst / idle cycles between bursts
//   num_bursts                bursts per sequence, 0 = run until stop
//   busy, done, overflow      status (overflow is sticky until next start)
//   gen_ce                    generator clock enable
//   gen_valid/gen_real/imag   generator output, fixed latency after gen_ce
//   m_tdata/tvalid/tready/tlast  AXI-Stream master, tdata = {imag, real}
module gng_burst_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16,
  parameter int GAP_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [7:0]       num_bursts,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             gen_ce,
  input  logic             gen_valid,
  input  logic [15:0]      gen_real,
  input  logic [15:0]      gen_imag,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] len_q, issued, rx;
  logic [GAP_W-1:0] gap_q, gap_cnt;
  logic [7:0]       nb_q, bursts_done;
  logic             stop_pend, done_q, overflow_q;
  logic [CW-1:0]    inflight, count;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [32:0]      mem [FIFO_DEPTH];

  logic accept_start, credit, burst_end, last_burst, rx_last;
  logic fifo_full, fifo_empty, rd_en, wr_en, drained;

  assign accept_start = (state == IDLE) && start && (burst_len != '0);
  // Credit counts samples already requested but not yet written, so the FIFO
  // can always absorb everything the generator still owes us.
  assign credit     = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign gen_ce     = (state == RUN) && credit;
  assign burst_end  = gen_ce && (issued == len_q - LEN_W'(1));
  assign last_burst = (nb_q != 8'd0) && (bursts_done + 8'd1 == nb_q);
  assign rx_last    = (rx == len_q - LEN_W'(1));
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign rd_en      = !fifo_empty && m_tready;
  // A full FIFO still accepts a write when a read frees a slot the same cycle.
  assign wr_en      = gen_valid && (!fifo_full || rd_en);
  assign drained    = (inflight == '0) && fifo_empty;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept_start) state_n = RUN;
      RUN:   if (burst_end) begin
               if (stop_pend || stop || last_burst) state_n = DRAIN;
               else if (gap_q == '0)                 state_n = RUN;
               else                                  state_n = GAP;
             end
      GAP:   if (stop)                                state_n = DRAIN;
             else if (gap_cnt == gap_q - GAP_W'(1))   state_n = RUN;
      DRAIN: if (drained)                             state_n = IDLE;
      default:                                        state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      nb_q        <= '0;
      issued      <= '0;
      bursts_done <= '0;
      gap_cnt     <= '0;
      stop_pend   <= 1'b0;
      rx          <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      inflight    <= '0;
    end else begin
      state   <= state_n;
      done_q  <= (state == DRAIN) && drained;
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (accept_start) begin
        len_q       <= burst_len;
        gap_q       <= gap_len;
        nb_q        <= num_bursts;
        issued      <= '0;
        bursts_done <= '0;
        stop_pend   <= 1'b0;
        rx          <= '0;
      end else begin
        if (gen_ce)    issued      <= burst_end ? '0 : issued + LEN_W'(1);
        if (burst_end) bursts_done <= bursts_done + 8'd1;
        if (stop && (state == RUN || state == GAP)) stop_pend <= 1'b1;
        if (gen_valid) rx <= rx_last ? '0 : rx + LEN_W'(1);
      end

      if (accept_start)                        overflow_q <= 1'b0;
      else if (gen_valid && fifo_full && !rd_en) overflow_q <= 1'b1;

      // A stray gen_valid with nothing outstanding must not wrap the counter,
      // otherwise DRAIN would never see inflight == 0.
      if (gen_ce && !gen_valid)
        inflight <= inflight + CW'(1);
      else if (!gen_ce && gen_valid && inflight != '0)
        inflight <= inflight - CW'(1);
    end
  end

  // NOTE: the sample storage has no reset; only pointers and count are reset,
  // and outputs are gated by m_tvalid so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {rx_last, gen_imag, gen_real};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign m_tvalid = !fifo_empty;
  assign m_tdata  = m_tvalid ? mem[rd_ptr][31:0] : '0;
  assign m_tlast  = m_tvalid && mem[rd_ptr][32];

endmodule

// File: tb/tb_gng_burst_ctrl.sv
// tb_gng_burst_ctrl
//   Directed bench for gng_burst_ctrl. A 3-cycle-latency generator model
//   returns a running sample index (real = idx, imag = idx ^ A5A5), so every
//   delivered word is predictable from the index at sequence start.
module tb_gng_burst_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [15:0] burst_len = '0, gap_len = '0;
  logic [7:0]  num_bursts = '0;
  logic        busy, done, overflow, gen_ce;
  logic        gen_valid;
  logic [15:0] gen_real, gen_imag;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b0;
  logic        force_valid = 1'b0;

  always #5 clk = ~clk;

  gng_burst_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .burst_len(burst_len), .gap_len(gap_len), .num_bursts(num_bursts),
    .busy(busy), .done(done), .overflow(overflow), .gen_ce(gen_ce),
    .gen_valid(gen_valid), .gen_real(gen_real), .gen_imag(gen_imag),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  // Generator model
  logic [2:0]  vpipe;
  logic [15:0] ipipe [3];
  logic [15:0] gen_idx;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe <= '0;
      gen_idx <= '0;
      for (int i = 0; i < 3; i++) ipipe[i] <= '0;
    end else begin
      vpipe    <= {vpipe[1:0], gen_ce};
      ipipe[0] <= gen_idx;
      ipipe[1] <= ipipe[0];
      ipipe[2] <= ipipe[1];
      if (gen_ce) gen_idx <= gen_idx + 16'd1;
    end
  end
  assign gen_valid = vpipe[2] | force_valid;
  assign gen_real  = ipipe[2];
  assign gen_imag  = ipipe[2] ^ 16'hA5A5;

  // Monitor: only this process writes these
  logic [32:0] beats[$];
  int          ce_pos[$];
  int          ce_cnt = 0, done_cnt = 0, cyc = 0;
  always @(posedge clk) begin
    if (rstn) begin
      if (m_tvalid && m_tready) beats.push_back({m_tlast, m_tdata});
      if (done) done_cnt++;
      if (gen_ce) begin ce_pos.push_back(cyc); ce_cnt++; end
    end
    cyc++;
  end

  int n_assert = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] exp_word(input logic last, input logic [15:0] idx);
    return {last, idx ^ 16'hA5A5, idx};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] len, input logic [15:0] gap, input logic [7:0] nb);
    @(negedge clk);
    burst_len = len; gap_len = gap; num_bursts = nb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d_before, input int max, input string tag);
    int k = 0;
    while (done_cnt == d_before && k < max) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(done_cnt > d_before), 64'd1);
  endtask

  task automatic check_beats(input string tag, input int b0, input int n,
                             input logic [15:0] base, input int len);
    check({tag, "_nbeats"}, 64'(beats.size() - b0), 64'(n));
    for (int k = 0; k < n; k++)
      check($sformatf("%s_beat%0d", tag, k), 64'(beats[b0 + k]),
            64'(exp_word((k % len) == len - 1, base + 16'(k))));
  endtask

  int b0, d0, c0;
  logic [15:0] base;

  initial begin
    // Reset state
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_gen_ce", 64'(gen_ce), 64'd0);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    tick(2);
    rstn = 1'b1;
    tick(2);

    // 1: single burst of 8, no gap
    m_tready = 1'b1;
    b0 = beats.size(); d0 = done_cnt; c0 = ce_cnt; base = gen_idx;
    do_start(16'd8, 16'd0, 8'd1);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(d0, 200, "t1_done_seen");
    tick(3);
    check_beats("t1", b0, 8, base, 8);
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);

    // 2: three bursts of 4 with a 5-cycle gap
    b0 = beats.size(); d0 = done_cnt; c0 = ce_cnt; base = gen_idx;
    do_start(16'd4, 16'd5, 8'd3);
    wait_done(d0, 300, "t2_done_seen");
    tick(3);
    check("t2_ce_total", 64'(ce_cnt - c0), 64'd12);
    check("t2_burst1_span", 64'(ce_pos[c0 + 3] - ce_pos[c0]), 64'd3);
    check("t2_gap1", 64'(ce_pos[c0 + 4] - ce_pos[c0 + 3]), 64'd6);
    check("t2_gap2", 64'(ce_pos[c0 + 8] - ce_pos[c0 + 7]), 64'd6);
    check("t2_burst3_span", 64'(ce_pos[c0 + 11] - ce_pos[c0 + 8]), 64'd3);
    check_beats("t2", b0, 12, base, 4);
    check("t2_done_once", 64'(done_cnt - d0), 64'd1);

    // 3: long burst against 50 cycles of backpressure
    m_tready = 1'b0;
    b0 = beats.size(); d0 = done_cnt; c0 = ce_cnt; base = gen_idx;
    do_start(16'd100, 16'd0, 8'd1);
    tick(50);
    check("t3_ce_stalled_total", 64'(ce_cnt - c0), 64'd16);
    check("t3_gen_ce_low", 64'(gen_ce), 64'd0);
    check("t3_no_overflow", 64'(overflow), 64'd0);
    check("t3_tvalid", 64'(m_tvalid), 64'd1);
    check("t3_head_word", 64'({m_tlast, m_tdata}), 64'(exp_word(1'b0, base)));
    tick(1);
    check("t3_head_stable", 64'({m_tlast, m_tdata}), 64'(exp_word(1'b0, base)));
    m_tready = 1'b1;
    wait_done(d0, 500, "t3_done_seen");
    tick(3);
    check_beats("t3", b0, 100, base, 100);
    check("t3_no_overflow_end", 64'(overflow), 64'd0);

    // 4: continuous mode, stop during burst 2
    b0 = beats.size(); d0 = done_cnt; c0 = ce_cnt; base = gen_idx;
    do_start(16'd10, 16'd0, 8'd0);
    for (int k = 0; k < 100 && (ce_cnt - c0) < 13; k++) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(d0, 300, "t4_done_seen");
    tick(5);
    check("t4_ce_total", 64'(ce_cnt - c0), 64'd20);
    check_beats("t4", b0, 20, base, 10);
    check("t4_done_once", 64'(done_cnt - d0), 64'd1);

    // 5: reset mid-run with FIFO partly filled
    m_tready = 1'b0;
    do_start(16'd100, 16'd0, 8'd1);
    tick(10);
    check("t5_pre_tvalid", 64'(m_tvalid), 64'd1);
    rstn = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_gen_ce", 64'(gen_ce), 64'd0);
    check("t5_tvalid", 64'(m_tvalid), 64'd0);
    check("t5_tlast", 64'(m_tlast), 64'd0);
    check("t5_tdata", 64'(m_tdata), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_overflow", 64'(overflow), 64'd0);
    tick(2);
    rstn = 1'b1;
    m_tready = 1'b1;
    tick(1);
    b0 = beats.size(); d0 = done_cnt; c0 = ce_cnt; base = gen_idx;
    do_start(16'd8, 16'd0, 8'd1);
    wait_done(d0, 200, "t5_done_seen");
    tick(3);
    check_beats("t5", b0, 8, base, 8);

    // 6: forced overflow, sticky until an accepted start
    m_tready = 1'b0;
    b0 = beats.size(); d0 = done_cnt; c0 = ce_cnt; base = gen_idx;
    do_start(16'd16, 16'd0, 8'd1);
    tick(30);
    check("t6_ce_total", 64'(ce_cnt - c0), 64'd16);
    check("t6_pre_overflow", 64'(overflow), 64'd0);
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    check("t6_overflow_set", 64'(overflow), 64'd1);
    m_tready = 1'b1;
    wait_done(d0, 200, "t6_done_seen");
    tick(3);
    check_beats("t6", b0, 16, base, 16);
    check("t6_overflow_sticky", 64'(overflow), 64'd1);
    do_start(16'd0, 16'd0, 8'd1);
    tick(2);
    check("t6_len0_busy", 64'(busy), 64'd0);
    check("t6_len0_overflow", 64'(overflow), 64'd1);
    b0 = beats.size(); d0 = done_cnt; base = gen_idx;
    do_start(16'd4, 16'd0, 8'd1);
    check("t6_restart_busy", 64'(busy), 64'd1);
    check("t6_overflow_cleared", 64'(overflow), 64'd0);
    wait_done(d0, 200, "t6b_done_seen");
    tick(3);
    check_beats("t6b", b0, 4, base, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
